// File: rtl/minilab_pkg.sv
// Shared types and default sizes for the matrix-vector MAC sequencer.
package minilab_pkg;

    localparam int DATA_WIDTH_DEF     = 8;
    localparam int MATRIX_COLUMNS_DEF = 8;
    localparam int ADDR_WIDTH_DEF     = 32;

    typedef enum logic [2:0] {
        IDLE,
        FILL_B,
        FILL_A,
        PREREAD,
        CLEAR,
        COMPUTE,
        DRAIN,
        DONE
    } state_t;

    function automatic logic is_fill(state_t s);
        return (s == FILL_B) || (s == FILL_A);
    endfunction

endpackage

// File: rtl/mac_sequencer_if.sv
// Bus bundle between the MAC sequencer, its operand memory, the operand FIFOs and the MAC chain.
interface mac_sequencer_if
    import minilab_pkg::*;
#(
    parameter int DATA_WIDTH       = DATA_WIDTH_DEF,
    parameter int MATRIX_COLUMNS_A = MATRIX_COLUMNS_DEF,
    parameter int ADDR_WIDTH       = ADDR_WIDTH_DEF
) ();

    logic                        start;
    logic [ADDR_WIDTH-1:0]       base_addr;
    // Read handshake: mem_rd rises with a stable mem_addr and stays high until the
    // cycle mem_valid is high; that cycle completes the read and carries mem_rdata.
    logic                        mem_rd;
    logic [ADDR_WIDTH-1:0]       mem_addr;
    logic                        mem_valid;
    logic [DATA_WIDTH-1:0]       mem_rdata;
    logic [DATA_WIDTH-1:0]       fifo_wdata;
    logic [MATRIX_COLUMNS_A-1:0] wrreq_a;
    logic                        wrreq_b;
    logic [MATRIX_COLUMNS_A-1:0] wrfull_a;
    logic                        wrfull_b;
    logic                        rdempty_all;
    logic                        preread;
    logic                        clr;
    logic                        en0;
    logic                        busy;
    logic                        done;
    state_t                      state_dbg;

    modport master (
        input  start, base_addr, mem_valid, mem_rdata, wrfull_a, wrfull_b, rdempty_all,
        output mem_rd, mem_addr, fifo_wdata, wrreq_a, wrreq_b, preread, clr, en0,
               busy, done, state_dbg
    );

    modport slave (
        output start, base_addr, mem_valid, mem_rdata, wrfull_a, wrfull_b, rdempty_all,
        input  mem_rd, mem_addr, fifo_wdata, wrreq_a, wrreq_b, preread, clr, en0,
               busy, done, state_dbg
    );

endinterface

// File: rtl/mac_sequencer.sv
// Loads vector B and matrix A from memory into operand FIFOs, then drives the
// preread/clear/enable sequence of an N-deep MAC chain and reports done.
module mac_sequencer
    import minilab_pkg::*;
#(
    parameter int DATA_WIDTH       = DATA_WIDTH_DEF,
    parameter int MATRIX_COLUMNS_A = MATRIX_COLUMNS_DEF,
    parameter int ADDR_WIDTH       = ADDR_WIDTH_DEF
) (
    input  logic            clk,
    input  logic            rst,
    mac_sequencer_if.master bus
);

    localparam int N  = MATRIX_COLUMNS_A;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t                state, state_nxt;
    logic [CW-1:0]         col, col_nxt;
    logic [CW-1:0]         row, row_nxt;
    logic [CW-1:0]         phase, phase_nxt;
    logic [ADDR_WIDTH-1:0] addr, addr_nxt;
    logic                  issued, issued_nxt;
    logic                  target_full;
    logic                  rd;
    logic                  wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            col    <= '0;
            row    <= '0;
            phase  <= '0;
            addr   <= '0;
            issued <= 1'b0;
        end else begin
            state  <= state_nxt;
            col    <= col_nxt;
            row    <= row_nxt;
            phase  <= phase_nxt;
            addr   <= addr_nxt;
            issued <= issued_nxt;
        end
    end

    always_comb begin
        target_full = (state == FILL_B) ? bus.wrfull_b : bus.wrfull_a[row];
        // Once a read is on the bus it is held regardless of the full flag.
        rd          = is_fill(state) && (issued || !target_full);
        wr          = rd && bus.mem_valid;
        issued_nxt  = rd && !bus.mem_valid;
        state_nxt   = state;
        col_nxt     = col;
        row_nxt     = row;
        phase_nxt   = phase;
        addr_nxt    = addr;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = FILL_B;
                    addr_nxt  = bus.base_addr;
                    col_nxt   = '0;
                    row_nxt   = '0;
                end
            end
            FILL_B: begin
                if (wr) begin
                    // B then row-major A are contiguous, so the address just steps by one.
                    addr_nxt = addr + ADDR_WIDTH'(1);
                    if (col == LAST) begin
                        col_nxt   = '0;
                        row_nxt   = '0;
                        state_nxt = FILL_A;
                    end else begin
                        col_nxt = col + CW'(1);
                    end
                end
            end
            FILL_A: begin
                if (wr) begin
                    addr_nxt = addr + ADDR_WIDTH'(1);
                    if (col == LAST) begin
                        col_nxt = '0;
                        if (row == LAST) begin
                            state_nxt = PREREAD;
                        end else begin
                            row_nxt = row + CW'(1);
                        end
                    end else begin
                        col_nxt = col + CW'(1);
                    end
                end
            end
            PREREAD: begin
                if (!bus.rdempty_all) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                phase_nxt = '0;
                state_nxt = COMPUTE;
            end
            COMPUTE: begin
                if (phase == LAST) begin
                    phase_nxt = '0;
                    state_nxt = DRAIN;
                end else begin
                    phase_nxt = phase + CW'(1);
                end
            end
            DRAIN: begin
                if (phase == LAST) begin
                    phase_nxt = '0;
                    state_nxt = DONE;
                end else begin
                    phase_nxt = phase + CW'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.mem_rd     = rd;
        bus.mem_addr   = addr;
        bus.fifo_wdata = wr ? bus.mem_rdata : '0;
        bus.wrreq_b    = wr && (state == FILL_B);
        bus.wrreq_a    = '0;
        if (wr && (state == FILL_A)) begin
            bus.wrreq_a[row] = 1'b1;
        end
        bus.preread    = (state == PREREAD) && !bus.rdempty_all;
        bus.clr        = (state == CLEAR);
        bus.en0        = (state == COMPUTE);
        bus.busy       = (state != IDLE);
        bus.done       = (state == DONE);
        bus.state_dbg  = state;
    end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of matrix elements and memory data.
REQ-002 Parameter MATRIX_COLUMNS_A, default 8, A rows and columns; also B length and MAC count.
REQ-003 Parameter ADDR_WIDTH, default 32, memory byte-address width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  one-cycle request to run one matrix-vector multiply; sampled only in IDLE.
REQ-007 base_addr  input  ADDR_WIDTH  operand base; sampled with accepted start.
REQ-008 mem_rd  output  1  read request; held high until mem_valid.
REQ-009 mem_addr  output  ADDR_WIDTH  read address; stable while mem_rd high.
REQ-010 mem_valid  input  1  read data valid; completes the outstanding read.
REQ-011 mem_rdata  input  DATA_WIDTH  read data.
REQ-012 fifo_wdata  output  DATA_WIDTH  write data shared by all operand FIFOs.
REQ-013 wrreq_a  output  MATRIX_COLUMNS_A  per-row write strobe for A FIFOs.
REQ-014 wrreq_b  output  1  write strobe for B FIFO.
REQ-015 wrfull_a  input  MATRIX_COLUMNS_A  A FIFO full flags.
REQ-016 wrfull_b  input  1  B FIFO full flag.
REQ-017 rdempty_all  input  1  OR of all A and B FIFO rdempty flags.
REQ-018 preread  output  1  one-cycle pulse loading first FIFO word to q.
REQ-019 clr  output  1  one-cycle pulse clearing all MAC accumulators.
REQ-020 en0  output  1  enable into MAC 0; EnOut chain propagates it.
REQ-021 busy  output  1  high in every state except IDLE.
REQ-022 done  output  1  one-cycle pulse; MAC Couts valid and held until next clr.

Function
REQ-023 States: IDLE, FILL_B, FILL_A, PREREAD, CLEAR, COMPUTE, DRAIN, DONE; state encoding is an enum.
REQ-024 IDLE -> FILL_B on start; base_addr latched, element counter cleared.
REQ-025 FILL_B: element k (0..N-1, N=MATRIX_COLUMNS_A) read from base+k, written to B FIFO via wrreq_b.
REQ-026 FILL_A: element (r,c) read from base+N+N*r+c, row-major, written to A FIFO r via wrreq_a[r].
REQ-027 One read outstanding at a time; FIFO write is a one-cycle strobe in the cycle mem_valid is high, fifo_wdata = mem_rdata that cycle.
REQ-028 Next mem_rd is asserted no earlier than the cycle after mem_valid.
REQ-029 mem_rd is not asserted while the target FIFO's wrfull is high; fill resumes when it clears.
REQ-030 Counters wrap: after k=N-1 go to FILL_A with r=c=0; c=N-1 increments r; r=c=N-1 completion -> PREREAD.
REQ-031 PREREAD: waits while rdempty_all high; preread pulses once when low, then CLEAR.
REQ-032 CLEAR: clr high exactly one cycle, then COMPUTE.
REQ-033 COMPUTE: en0 high exactly N consecutive cycles, then DRAIN.
REQ-034 DRAIN: N cycles with en0 low, covering chain propagation through MAC N-1, then DONE.
REQ-035 DONE: done high one cycle, return to IDLE; busy low the following cycle.
REQ-036 Latency start to done with zero-wait memory (mem_valid the cycle after mem_rd) and no stalls: 2*N*(N+1) fill cycles + 1 PREREAD + 1 CLEAR + N + N + 1, plus 1 start-accept cycle.
REQ-037 start while busy ignored; mem_valid outside FILL states ignored.
REQ-038 mem_valid and start both high in the same cycle: start ignored if busy.
REQ-039 Address arithmetic modulo 2^ADDR_WIDTH; no wrap detection.

Reset
REQ-040 rst high immediately forces IDLE, counters to 0, and outputs to 0: mem_rd, mem_addr, wrreq_a, wrreq_b, fifo_wdata, preread, clr, en0, busy, done.
REQ-041 Reset mid-operation abandons the outstanding read; mem_valid arriving after reset is ignored.

Structure
REQ-042 State enum, DATA_WIDTH and MATRIX_COLUMNS_A defaults in shared package minilab_pkg.
REQ-043 No sub-modules; one FSM plus element counter, row counter and phase counter.

Verification
REQ-044 Zero-wait memory, B=1..8, A(r,c)=r+c: exactly 72 FIFO writes in order; done at REQ-036 cycle; MAC r result = sum_c (r+c)*(c+1).
REQ-045 Random 0-5 cycle mem_valid delay: write sequence and data identical to zero-wait case; never two outstanding reads.
REQ-046 Hold wrfull_a[3] high 20 cycles during row 3: mem_rd low throughout, no wrreq_a[3], resume with no lost or duplicated element.
REQ-047 start pulsed in COMPUTE: ignored; exactly one done; en0 high exactly 8 cycles.
REQ-048 rst asserted in FILL_A at r=2,c=5: all outputs 0 same cycle; later start refills from k=0.
REQ-049 rdempty_all held high 10 cycles in PREREAD: no preread until low, then exactly one preread pulse.
